// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with flush and a saturating stall counter.
// Latency: one cycle from accept to out_valid; sustains one entry per cycle when out_ready stays high.
// Backpressure: in_ready is registered and low only while skid is full, so it has no combinational path from out_ready.
module pipe_skid_reg #(
    parameter int           XLEN  = 32,
    parameter int           ILEN  = 32,
    parameter logic [ILEN-1:0] NOP = 32'h00000013,
    parameter int           CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic            main_vld, skid_vld;
    logic [XLEN-1:0] main_pc, skid_pc;
    logic [ILEN-1:0] main_instr, skid_instr;
    logic            in_ready_q;

    logic            main_vld_nxt, skid_vld_nxt;
    logic [XLEN-1:0] main_pc_nxt, skid_pc_nxt;
    logic [ILEN-1:0] main_instr_nxt, skid_instr_nxt;

    logic pop, acc, stalled;

    // Handshakes; flush overrides both pop and accept.
    assign pop     = main_vld & out_ready & ~flush;
    assign acc     = in_valid & in_ready_q & ~flush;
    assign stalled = main_vld & ~out_ready;

    // Next-state for the two entries; an empty main always shows pc 0 / NOP.
    always_comb begin
        main_vld_nxt   = main_vld;
        main_pc_nxt    = main_pc;
        main_instr_nxt = main_instr;
        skid_vld_nxt   = skid_vld;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        if (flush) begin
            main_vld_nxt   = 1'b0;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP;
            skid_vld_nxt   = 1'b0;
        end else if (skid_vld) begin
            // in_ready is low here, so only a pop can change state.
            if (pop) begin
                main_pc_nxt    = skid_pc;
                main_instr_nxt = skid_instr;
                skid_vld_nxt   = 1'b0;
            end
        end else if (acc) begin
            if (!main_vld || pop) begin
                main_vld_nxt   = 1'b1;
                main_pc_nxt    = in_pc;
                main_instr_nxt = in_instr;
            end else begin
                skid_vld_nxt   = 1'b1;
                skid_pc_nxt    = in_pc;
                skid_instr_nxt = in_instr;
            end
        end else if (pop) begin
            main_vld_nxt   = 1'b0;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP;
        end
    end

    // Entry state and the registered ready, which mirrors the next skid emptiness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld   <= 1'b0;
            main_pc    <= '0;
            main_instr <= NOP;
            skid_vld   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP;
            in_ready_q <= 1'b1;
        end else begin
            main_vld   <= main_vld_nxt;
            main_pc    <= main_pc_nxt;
            main_instr <= main_instr_nxt;
            skid_vld   <= skid_vld_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            in_ready_q <= ~skid_vld_nxt;
        end
    end

    // Stall counter: counts cycles the head is held, saturates, and ignores flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_pc    = main_pc;
    assign out_instr = main_instr;
    // skid is only ever full while main is full.
    assign occupancy = {main_vld & skid_vld, main_vld ^ skid_vld};

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          CW  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_pc, in_instr, out_pc, out_instr;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int   total = 0;
    int   bad   = 0;
    ent_t sb[$];
    int   stall_exp = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.XLEN(32), .ILEN(32), .NOP(NOP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every visible output against the reference FIFO model.
    task automatic chk_state(input string tag);
        chk({tag, ".occ"}, 32'(occupancy), 32'(sb.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(sb.size() < 2));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() > 0));
        chk({tag, ".out_pc"}, out_pc, (sb.size() > 0) ? sb[0].pc : 32'h0);
        chk({tag, ".out_instr"}, out_instr, (sb.size() > 0) ? sb[0].instr : NOP);
        chk({tag, ".stall"}, 32'(stall_cnt), 32'(stall_exp));
    endtask

    // One clock: capture handshakes before the edge, update the model, check after it.
    task automatic tick(input string tag);
        ent_t e;
        logic pop, acc;
        pop = out_valid && out_ready;
        acc = in_valid && in_ready && !flush;
        if (sb.size() > 0 && !out_ready && stall_exp < (1 << CW) - 1) stall_exp++;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop) begin
                if (sb.size() == 0) begin
                    chk({tag, ".pop_unexpected"}, 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, ".pop_pc"}, out_pc, e.pc);
                    chk({tag, ".pop_instr"}, out_instr, e.instr);
                end
            end
            if (acc) sb.push_back('{pc: in_pc, instr: in_instr});
        end
        @(posedge clk);
        #1;
        chk_state(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom;
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk_state("reset_async");
        @(posedge clk); #1;
        chk_state("reset_held");
        reset = 1'b0;
        tick("idle");

        // Streaming: one per cycle, occupancy stays 1.
        drive(1'b1, 32'h0, 1'b1, 1'b0); tick("stream0");
        drive(1'b1, 32'h4, 1'b1, 1'b0); tick("stream4");
        drive(1'b1, 32'h8, 1'b1, 1'b0); tick("stream8");
        // Simultaneous pop and push with occupancy 1.
        drive(1'b1, 32'h20, 1'b1, 1'b0); tick("poppush");
        chk("poppush.main", out_pc, 32'h20);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick("drain1");

        // Stall saturation: one held entry, five stalled cycles.
        drive(1'b1, 32'h30, 1'b0, 1'b0); tick("stall_load");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick("stall");
        chk("stall.sat", 32'(stall_cnt), 32'h3);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick("stall_release");

        // Backpressure: fill main and skid, then drain in order.
        drive(1'b1, 32'h10, 1'b0, 1'b0); tick("bp10");
        drive(1'b1, 32'h14, 1'b0, 1'b0); tick("bp14");
        drive(1'b1, 32'h18, 1'b0, 1'b0); tick("bp_blocked");
        chk("bp.in_ready", 32'(in_ready), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick("bp_out10");
        tick("bp_out14");

        // Flush with skid full and a concurrent push.
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick("fl_a");
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick("fl_b");
        drive(1'b1, 32'h48, 1'b1, 1'b1); tick("flush");
        chk("flush.instr", out_instr, NOP);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick("post_flush");

        // Asynchronous reset between edges with occupancy 2.
        drive(1'b1, 32'h50, 1'b0, 1'b0); tick("ar_a");
        drive(1'b1, 32'h54, 1'b0, 1'b0); tick("ar_b");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        stall_exp = 0;
        chk_state("areset");
        @(posedge clk); #1;
        reset = 1'b0;
        chk_state("areset_held");
        drive(1'b1, 32'h60, 1'b1, 1'b0); tick("after_reset");

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
            tick("rand");
        end

        // Bounded drain.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick("drain");
        chk("drain.empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
